memory_stage_without_buffers: RTL and testbench

Memory stage of the 16-bit RISC pipeline, without the surrounding pipeline registers. It contains the word-addressed data memory and the stack pointer (SP). It performs loads, stores, pushes and pops. Writes can store the PC halves, the flags, or a store operand, so CALL and interrupt context can be saved to the stack.

---
 rtl/memory_stage_without_buffers.sv | 85 ++++++++
 tb/tb_memory_stage_without_buffers.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/memory_stage_without_buffers.sv
// Memory stage of the 16-bit RISC pipeline: word-addressed data memory plus stack pointer.
// Single-cycle loads/stores/push/pop; read data is registered; no handshake, never stalls.
module memory_stage_without_buffers #(
  parameter int                    ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET   = {ADDR_WIDTH{1'b1}}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic        memory_push,
  input  logic        memory_pop,
  input  logic [15:0] std_address,
  input  logic [15:0] ldd_address,
  input  logic [1:0]  memory_address_select,
  input  logic [1:0]  memory_write_src_select,
  input  logic [31:0] pc,
  input  logic [2:0]  flags,
  output logic [15:0] data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] SP_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [15:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] sp;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           wdata;
  logic                  pop_only;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{std_address[15:ADDR_WIDTH], ldd_address[15:ADDR_WIDTH]};

  // Push wins when both push and pop are requested.
  assign pop_only = memory_pop & ~memory_push;

  // A pop reads the slot above SP, since SP always points at the next free word.
  always_comb begin
    addr = sp;
    case (memory_address_select)
      2'b00:   addr = pop_only ? sp + SP_ONE : sp;
      2'b01:   addr = std_address[ADDR_WIDTH-1:0];
      2'b10:   addr = ldd_address[ADDR_WIDTH-1:0];
      default: addr = sp;
    endcase
  end

  always_comb begin
    wdata = std_address;
    case (memory_write_src_select)
      2'b00:   wdata = pc[15:0];
      2'b01:   wdata = pc[31:16];
      2'b10:   wdata = {13'b0, flags};
      default: wdata = std_address;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (memory_write) begin
      mem[addr] <= wdata;
    end
  end

  // Reads see pre-edge memory contents, giving read-before-write on a shared address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (memory_read) begin
      data <= mem[addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= SP_RESET;
    end else if (memory_push) begin
      sp <= sp - SP_ONE;
    end else if (memory_pop) begin
      sp <= sp + SP_ONE;
    end
  end

endmodule

// File: tb/tb_memory_stage_without_buffers.sv
// Directed bench for memory_stage_without_buffers: reference memory/SP model feeding a read-data scoreboard,
// plus fixed expected values for the push/pop, store/load, push+pop, read-before-write and reset cases.
module tb_memory_stage_without_buffers;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic        memory_push = 1'b0;
  logic        memory_pop = 1'b0;
  logic [15:0] std_address = '0;
  logic [15:0] ldd_address = '0;
  logic [1:0]  memory_address_select = '0;
  logic [1:0]  memory_write_src_select = '0;
  logic [31:0] pc = '0;
  logic [2:0]  flags = '0;
  logic [15:0] data;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m [2048];
  logic [10:0] msp;
  logic [15:0] exp_q [$];

  memory_stage_without_buffers dut (
    .clk                     (clk),
    .reset                   (reset),
    .memory_read             (memory_read),
    .memory_write            (memory_write),
    .memory_push             (memory_push),
    .memory_pop              (memory_pop),
    .std_address             (std_address),
    .ldd_address             (ldd_address),
    .memory_address_select   (memory_address_select),
    .memory_write_src_select (memory_write_src_select),
    .pc                      (pc),
    .flags                   (flags),
    .data                    (data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2048; i++) m[i] = '0;
    msp = 11'd2047;
    exp_q.delete();
  endtask

  // One clock: predict from the model, step the DUT, then score data and SP.
  task automatic cycle(input string tag);
    logic [10:0] a;
    logic [15:0] w;
    logic        rd;
    case (memory_address_select)
      2'b00:   a = (memory_pop && !memory_push) ? msp + 11'd1 : msp;
      2'b01:   a = std_address[10:0];
      2'b10:   a = ldd_address[10:0];
      default: a = msp;
    endcase
    case (memory_write_src_select)
      2'b00:   w = pc[15:0];
      2'b01:   w = pc[31:16];
      2'b10:   w = {13'b0, flags};
      default: w = std_address;
    endcase
    rd = memory_read;
    if (rd) exp_q.push_back(m[a]);
    if (memory_write) m[a] = w;
    if (memory_push) msp = msp - 11'd1;
    else if (memory_pop) msp = msp + 11'd1;
    @(posedge clk);
    #1;
    if (rd) chk({tag, "_data"}, data, exp_q.pop_front());
    chk({tag, "_sp"}, {5'b0, dut.sp}, {5'b0, msp});
  endtask

  initial begin
    logic [15:0] pop_data [5];
    logic [10:0] pop_sp [5];
    int nonzero;
    pop_data = '{16'h0014, 16'h0007, 16'hDCBA, 16'hABCD, 16'h0000};
    pop_sp   = '{11'd2044, 11'd2045, 11'd2046, 11'd2047, 11'd0};
    model_reset();

    // Reset before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_data", data, 16'h0000);
    chk("rst_sp", {5'b0, dut.sp}, 16'd2047);
    nonzero = 0;
    for (int i = 0; i < 2048; i++) if (dut.mem[i] !== 16'h0000) nonzero++;
    chk("rst_mem_nonzero", nonzero[15:0], 16'd0);
    #9 reset = 1'b0;

    // Push PC halves, flags and store operand
    pc = 32'hDCBA_ABCD; flags = 3'b111; std_address = 16'h0014;
    memory_write = 1'b1; memory_push = 1'b1; memory_address_select = 2'b00;
    for (int s = 0; s < 4; s++) begin
      memory_write_src_select = s[1:0];
      cycle("push");
    end
    chk("push_m2047", dut.mem[2047], 16'hABCD);
    chk("push_m2046", dut.mem[2046], 16'hDCBA);
    chk("push_m2045", dut.mem[2045], 16'h0007);
    chk("push_m2044", dut.mem[2044], 16'h0014);
    chk("push_sp", {5'b0, dut.sp}, 16'd2043);

    // Pop back, last pop wraps SP to 0
    memory_write = 1'b0; memory_push = 1'b0; memory_pop = 1'b1; memory_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle("pop");
      chk("pop_data_fixed", data, pop_data[k]);
      chk("pop_sp_fixed", {5'b0, dut.sp}, {5'b0, pop_sp[k]});
    end

    // Store then load through effective addresses
    memory_pop = 1'b0; memory_read = 1'b0;
    memory_address_select = 2'b01; std_address = 16'h0005;
    memory_write_src_select = 2'b11; memory_write = 1'b1;
    cycle("store");
    chk("store_m5", dut.mem[5], 16'h0005);
    memory_write = 1'b0; memory_address_select = 2'b10; ldd_address = 16'h0005; memory_read = 1'b1;
    cycle("load");
    chk("load_data_fixed", data, 16'h0005);
    chk("load_sp_fixed", {5'b0, dut.sp}, 16'd0);

    // Push and pop together: push wins
    memory_read = 1'b0; memory_address_select = 2'b00;
    memory_push = 1'b1; memory_pop = 1'b1; memory_write = 1'b1;
    memory_write_src_select = 2'b00; pc = 32'h0000_1234;
    cycle("pushpop");
    chk("pushpop_m0", dut.mem[0], 16'h1234);
    chk("pushpop_sp", {5'b0, dut.sp}, 16'd2047);

    // Push with a non-stack address: SP moves, write goes to ldd_address
    memory_pop = 1'b0; memory_address_select = 2'b10; ldd_address = 16'hF807;
    memory_write_src_select = 2'b10; flags = 3'b101;
    cycle("push_sel10");
    chk("push_sel10_m7", dut.mem[7], 16'h0005);
    chk("push_sel10_sp", {5'b0, dut.sp}, 16'd2046);

    // Read-before-write, then read-back, then hold
    memory_push = 1'b0; memory_address_select = 2'b01; std_address = 16'hAAAA;
    memory_write_src_select = 2'b11; memory_write = 1'b1; memory_read = 1'b1;
    cycle("rbw");
    chk("rbw_old", data, 16'h0000);
    memory_write = 1'b0;
    cycle("rbw_new");
    chk("rbw_new_fixed", data, 16'hAAAA);
    memory_read = 1'b0; std_address = 16'h0005;
    cycle("hold");
    chk("hold_fixed", data, 16'hAAAA);

    // Asynchronous reset mid-cycle
    #3 reset = 1'b1;
    #1;
    chk("arst_data", data, 16'h0000);
    chk("arst_sp", {5'b0, dut.sp}, 16'd2047);
    chk("arst_m2aa", dut.mem[11'h2AA], 16'h0000);
    model_reset();
    #2 reset = 1'b0;
    memory_address_select = 2'b00; memory_read = 1'b1; memory_pop = 1'b1;
    cycle("post_rst_pop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
